vscale_hasti_arbiter: RTL and testbench
=======================================

# vscale_hasti_arbiter

Parametrised N-master to 1-slave AHB-lite (HASTI) arbiter, the successor to the fixed two-port imem/dmem wrapper. It lets N core-side bridge masters share one slave port. Each master gets a one-entry address-phase input stage so it is never stalled in its address phase. Arbitration is round-robin with `hmastlock`-based grant hold. The block sits between the `vscale_hasti_bridge` instances and the memory/peripheral slave.

## Interface
- `N_MASTERS`, default 2: number of master ports (≥2).
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `hclk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `m_haddr` input N*ADDR_WIDTH: per-master address, master i at slice i.
- `m_hwrite` input N: per-master write flag.
- `m_hsize` input 3N: per-master size.
- `m_hprot` input 4N: per-master protection.
- `m_hmastlock` input N: per-master lock request.
- `m_htrans` input 2N: per-master transfer type.
- `m_hwdata` input N*DATA_WIDTH: per-master write data.
- `m_hrdata` output N*DATA_WIDTH: read data, slave `s_hrdata` broadcast.
- `m_hready` output N: per-master ready.
- `m_hresp` output N: per-master response.
- `s_haddr`, `s_hwrite`, `s_hsize`, `s_hprot`, `s_hmastlock`, `s_htrans` output, same widths as one master: slave address phase.
- `s_hburst` output 3: constant SINGLE (3'b000).
- `s_hwdata` output DATA_WIDTH: slave write data.
- `s_hrdata` input DATA_WIDTH: slave read data.
- `s_hready` input 1: slave ready.
- `s_hresp` input 1: slave response.

## Operation
- Outstanding (i): master i has a pending entry, or `dp_valid && dp_owner==i`.
- `m_hready[i]`:
  - not outstanding: 1;
  - outstanding: `s_hready && dp_valid && dp_owner==i && !pend_valid[i]`.
- `m_hresp[i]`: `s_hresp` when `dp_valid && dp_owner==i`, else 0.
- Accept: master i's address phase is accepted when `m_hready[i]==1` and `m_htrans[i]` is NONSEQ or SEQ. SEQ is treated as NONSEQ.
- Candidate i: `pend_valid[i]` (use the pending fields), else an accepted live request (use the live fields).
- Issue: only in cycles with `s_hready==1`.
  - Winner = first candidate scanning from `(rr_last+1) mod N` upward.
  - Lock override: if `lock_valid`, only `lock_owner` may win.
  - Slave outputs take the winner's fields; `s_htrans`=NONSEQ.
  - Update: `rr_last`←winner, `dp_owner`←winner, `dp_valid`←1, winner's `pend_valid` cleared.
- No issue: `s_htrans`=IDLE and the other address outputs are 0. If `s_hready==1`, `dp_valid`←0.
- Capture: an accepted live request that does not win in that cycle (not granted, or `s_hready==0`) is written into `pending[i]`: addr, write, size, prot, mastlock. `pend_valid[i]`←1.
- Depth: at most one pending entry per master. A second request cannot be accepted because `m_hready[i]` is 0 while outstanding.
- `s_hwdata` = `m_hwdata` slice of `dp_owner`. The master holds it stable because its `hready` stays low until its data phase completes.
- Lock:
  - Set: on issue with `hmastlock==1` → `lock_valid`←1, `lock_owner`←winner.
  - Clear: any `s_hready==1` cycle in which `lock_owner` presents `m_hmastlock==0` and has no pending entry.
- Reset values:
  - Registers: `pend_valid`=0, `dp_valid`=0, `lock_valid`=0, `rr_last`=N_MASTERS-1 (master 0 has first priority).
  - Outputs: `s_htrans`=IDLE, all `m_hready`=1, all `m_hresp`=0.
- Reset mid-transfer: all state is discarded. Any in-flight slave data phase is abandoned; the system resets the slave with the same signal.

## Timing
- Granted directly: address reaches the slave the same cycle; the data phase completes in the next `s_hready` cycle. Zero added latency.
- Captured: ≥1 added cycle per losing arbitration round; worst-case wait is N-1 issues.
- Back-to-back: a master completing its data phase may present its next address the same cycle; it is eligible immediately.
- Wait states: while `s_hready==0`, there are no issues and no pending clears, and `dp_owner` is stable.
- ERROR response: both response cycles forward `s_hresp` to `dp_owner` only. The first cycle shows `m_hready`=0, `m_hresp`=1.

## Test plan
- Single read: after reset, m0 NONSEQ read at 0x100 → `s_haddr`=0x100 and `s_htrans`=NONSEQ the same cycle, `m_hready[0]`=1. Next cycle `s_hrdata`=0xDEADBEEF with `s_hready`=1 → `m_hready[0]`=1 and m0 sees 0xDEADBEEF.
- Collision: m0 and m1 request 0x10/0x20 in the same cycle → 0x10 issued, m1 captured. 0x20 issued next cycle. `m_hready[1]`=0 until cycle +2.
- Fairness: m0 and m1 issue 4 continuous reads each → slave order 0,1,0,1,0,1,0,1.
- Wait states: m0 write 0xA5A5A5A5 with `s_hready` low 2 cycles; m1 request pending → `s_hwdata` held at 0xA5A5A5A5; m1 issued only on the first `s_hready`=1 cycle.
- Lock: m1 issues 3 locked transfers while m0 requests → all 3 m1 transfers precede m0; m0 issued after m1 drops `hmastlock`.
- Error and reset: slave ERROR on m0 → `m_hresp[0]`=1 for 2 cycles, `m_hresp[1]`=0. Assert `reset` with m1 pending → the next cycle shows `s_htrans`=IDLE and all `m_hready`=1.

Source files
------------

// File: rtl/vscale_hasti_arbiter_if.sv
// Signal bundle between N core-side HASTI bridge masters, the arbiter and the shared slave.
// Per-master signals are flat vectors; master i occupies slice i.
interface vscale_hasti_arbiter_if #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_haddr;
  logic [N_MASTERS-1:0]            m_hwrite;
  logic [3*N_MASTERS-1:0]          m_hsize;
  logic [4*N_MASTERS-1:0]          m_hprot;
  logic [N_MASTERS-1:0]            m_hmastlock;
  logic [2*N_MASTERS-1:0]          m_htrans;
  logic [N_MASTERS*DATA_WIDTH-1:0] m_hwdata;
  logic [N_MASTERS*DATA_WIDTH-1:0] m_hrdata;
  logic [N_MASTERS-1:0]            m_hready;
  logic [N_MASTERS-1:0]            m_hresp;

  logic [ADDR_WIDTH-1:0]           s_haddr;
  logic                            s_hwrite;
  logic [2:0]                      s_hsize;
  logic [3:0]                      s_hprot;
  logic                            s_hmastlock;
  logic [1:0]                      s_htrans;
  logic [2:0]                      s_hburst;
  logic [DATA_WIDTH-1:0]           s_hwdata;
  logic [DATA_WIDTH-1:0]           s_hrdata;
  logic                            s_hready;
  logic                            s_hresp;

  // slave: the arbiter (it serves the bridge masters); master: the bridges plus the memory slave.
  modport slave (
    input  m_haddr, m_hwrite, m_hsize, m_hprot, m_hmastlock, m_htrans, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_haddr, s_hwrite, s_hsize, s_hprot, s_hmastlock, s_htrans, s_hburst, s_hwdata,
    input  s_hrdata, s_hready, s_hresp
  );

  modport master (
    output m_haddr, m_hwrite, m_hsize, m_hprot, m_hmastlock, m_htrans, m_hwdata,
    input  m_hrdata, m_hready, m_hresp,
    input  s_haddr, s_hwrite, s_hsize, s_hprot, s_hmastlock, s_htrans, s_hburst, s_hwdata,
    output s_hrdata, s_hready, s_hresp
  );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// N-master to 1-slave AHB-lite arbiter: round-robin grant, hmastlock hold, and a
// one-entry address-phase buffer per master so no master stalls in its address phase.
module vscale_hasti_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                   hclk,
  input logic                   reset,
  vscale_hasti_arbiter_if.slave bus
);
  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  logic [N_MASTERS-1:0]  pend_valid;
  logic [N_MASTERS-1:0]  pend_write;
  logic [N_MASTERS-1:0]  pend_lock;
  logic [ADDR_WIDTH-1:0] pend_addr [N_MASTERS];
  logic [2:0]            pend_size [N_MASTERS];
  logic [3:0]            pend_prot [N_MASTERS];
  logic                  dp_valid;
  logic                  lock_valid;
  idx_t                  dp_owner;
  idx_t                  lock_owner;
  idx_t                  rr_last;

  logic [ADDR_WIDTH-1:0] live_addr  [N_MASTERS];
  logic [2:0]            live_size  [N_MASTERS];
  logic [3:0]            live_prot  [N_MASTERS];
  logic [DATA_WIDTH-1:0] live_wdata [N_MASTERS];
  logic [N_MASTERS-1:0]  owns_dp, ready, accept, cand, grant, capture;
  logic                  issue, lock_clear;
  idx_t                  winner;
  int                    j_scan;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_write, win_lock;
  logic [2:0]            win_size;
  logic [3:0]            win_prot;

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      live_addr[i]  = bus.m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      live_size[i]  = bus.m_hsize[3*i +: 3];
      live_prot[i]  = bus.m_hprot[4*i +: 4];
      live_wdata[i] = bus.m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
      owns_dp[i]    = dp_valid && (dp_owner == idx_t'(i));
      // An outstanding master is only released as its own data phase completes with nothing buffered.
      ready[i]      = (pend_valid[i] || owns_dp[i]) ?
                      (bus.s_hready && owns_dp[i] && !pend_valid[i]) : 1'b1;
      accept[i]     = ready[i] && ((bus.m_htrans[2*i +: 2] == HTRANS_NONSEQ) ||
                                   (bus.m_htrans[2*i +: 2] == HTRANS_SEQ));
      cand[i]       = pend_valid[i] || accept[i];
    end
  end

  always_comb begin
    issue  = 1'b0;
    winner = rr_last;
    j_scan = 0;
    if (bus.s_hready) begin
      if (lock_valid) begin
        issue  = cand[lock_owner];
        winner = lock_owner;
      end else begin
        for (int k = 1; k <= N_MASTERS; k++) begin
          j_scan = int'(rr_last) + k;
          if (j_scan >= N_MASTERS) j_scan = j_scan - N_MASTERS;
          if (!issue && cand[idx_t'(j_scan)]) begin
            issue  = 1'b1;
            winner = idx_t'(j_scan);
          end
        end
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      grant[i]   = issue && (winner == idx_t'(i));
      capture[i] = accept[i] && !grant[i];
    end
    lock_clear = bus.s_hready && lock_valid && !bus.m_hmastlock[lock_owner] &&
                 !pend_valid[lock_owner];
  end

  always_comb begin
    if (pend_valid[winner]) begin
      win_addr  = pend_addr[winner];
      win_write = pend_write[winner];
      win_size  = pend_size[winner];
      win_prot  = pend_prot[winner];
      win_lock  = pend_lock[winner];
    end else begin
      win_addr  = live_addr[winner];
      win_write = bus.m_hwrite[winner];
      win_size  = live_size[winner];
      win_prot  = live_prot[winner];
      win_lock  = bus.m_hmastlock[winner];
    end
  end

  assign bus.s_htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.s_haddr     = issue ? win_addr  : '0;
  assign bus.s_hwrite    = issue && win_write;
  assign bus.s_hsize     = issue ? win_size  : 3'b000;
  assign bus.s_hprot     = issue ? win_prot  : 4'b0000;
  assign bus.s_hmastlock = issue && win_lock;
  assign bus.s_hburst    = 3'b000;
  assign bus.s_hwdata    = live_wdata[dp_owner];
  assign bus.m_hrdata    = {N_MASTERS{bus.s_hrdata}};
  assign bus.m_hready    = ready;
  assign bus.m_hresp     = owns_dp & {N_MASTERS{bus.s_hresp}};

  // Address-phase issue boundary: grant, data-phase ownership and lock state.
  always_ff @(posedge hclk) begin
    if (reset) begin
      pend_valid <= '0;
      dp_valid   <= 1'b0;
      lock_valid <= 1'b0;
      dp_owner   <= '0;
      lock_owner <= '0;
      rr_last    <= idx_t'(N_MASTERS - 1);
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant[i])        pend_valid[i] <= 1'b0;
        else if (capture[i]) pend_valid[i] <= 1'b1;
      end
      if (issue) begin
        rr_last  <= winner;
        dp_owner <= winner;
        dp_valid <= 1'b1;
      end else if (bus.s_hready) begin
        dp_valid <= 1'b0;
      end
      if (issue && win_lock) begin
        lock_valid <= 1'b1;
        lock_owner <= winner;
      end else if (lock_clear) begin
        lock_valid <= 1'b0;
      end
    end
  end

  // Buffered address-phase fields, only meaningful while pend_valid is set.
  always_ff @(posedge hclk) begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (capture[i]) begin
        pend_addr[i]  <= live_addr[i];
        pend_write[i] <= bus.m_hwrite[i];
        pend_size[i]  <= live_size[i];
        pend_prot[i]  <= live_prot[i];
        pend_lock[i]  <= bus.m_hmastlock[i];
      end
    end
  end
endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: queue-driven masters, a scripted slave, and a
// transaction-level reference of the arbitration rules checked every cycle.
module tb_vscale_hasti_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic hclk = 1'b0;
  logic reset;
  always #5 hclk = ~hclk;

  vscale_hasti_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  vscale_hasti_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk (hclk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]    trans;
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [3:0]    prot;
    logic          lock;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    bit            v;
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [3:0]    prot;
    logic          lock;
  } pend_t;

  req_t          mq [N][$];
  logic [DW-1:0] wd [N];
  logic [AW-1:0] issued [$];
  logic          rst_v, sr, sp;
  logic [DW-1:0] srd;

  pend_t mp [N];
  int    m_dp, m_lock, m_last;
  int    e_win;
  bit    e_rdy [N];
  bit    e_live [N];
  bit    e_clear, e_sready;
  pend_t e_fields;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(logic [1:0] t, logic [AW-1:0] a, logic w, logic lk, logic [DW-1:0] d);
    req_t r;
    r.trans = t; r.addr = a; r.write = w; r.size = 3'b010; r.prot = 4'b0011;
    r.lock = lk; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    if ($urandom_range(0, 4) != 0) r.trans = ($urandom_range(0, 1) != 0) ? SEQ : NONSEQ;
    else                           r.trans = ($urandom_range(0, 1) != 0) ? BUSY : IDLE;
    r.addr  = $urandom & 32'hFFFF_FFFC;
    r.write = ($urandom_range(0, 1) != 0);
    r.size  = 3'($urandom_range(0, 2));
    r.prot  = 4'($urandom_range(0, 15));
    r.lock  = ($urandom_range(0, 7) == 0);
    r.wdata = $urandom;
    return r;
  endfunction

  function automatic pend_t live_fields(int i);
    pend_t p;
    p.v     = 1'b1;
    p.addr  = bus.m_haddr[i*AW +: AW];
    p.write = bus.m_hwrite[i];
    p.size  = bus.m_hsize[3*i +: 3];
    p.prot  = bus.m_hprot[4*i +: 4];
    p.lock  = bus.m_hmastlock[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mp[i].v = 1'b0;
      mq[i].delete();
    end
    m_dp = -1; m_lock = -1; m_last = N - 1;
  endtask

  task automatic drive();
    req_t r;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) r = mq[i][0];
      else                  r = mk(IDLE, '0, 1'b0, 1'b0, '0);
      bus.m_htrans[2*i +: 2]  = r.trans;
      bus.m_haddr[i*AW +: AW] = r.addr;
      bus.m_hwrite[i]         = r.write;
      bus.m_hsize[3*i +: 3]   = r.size;
      bus.m_hprot[4*i +: 4]   = r.prot;
      bus.m_hmastlock[i]      = r.lock;
      bus.m_hwdata[i*DW +: DW] = wd[i];
    end
    bus.s_hready = sr;
    bus.s_hresp  = sp;
    bus.s_hrdata = srd;
    reset        = rst_v;
  endtask

  task automatic eval();
    logic [1:0]   tr;
    logic [N-1:0] er, ep;
    int           j;
    @(negedge hclk);
    e_sready = bus.s_hready;
    for (int i = 0; i < N; i++) begin
      tr        = bus.m_htrans[2*i +: 2];
      e_rdy[i]  = !(mp[i].v || m_dp == i) || (e_sready && m_dp == i && !mp[i].v);
      e_live[i] = e_rdy[i] && (tr == NONSEQ || tr == SEQ);
      er[i]     = e_rdy[i];
      ep[i]     = (m_dp == i) && bus.s_hresp;
    end
    e_win = -1;
    if (e_sready) begin
      if (m_lock >= 0) begin
        if (mp[m_lock].v || e_live[m_lock]) e_win = m_lock;
      end else begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (e_win < 0 && (mp[j].v || e_live[j])) e_win = j;
        end
      end
    end
    if (e_win >= 0) e_fields = mp[e_win].v ? mp[e_win] : live_fields(e_win);
    e_clear = e_sready && m_lock >= 0 && !bus.m_hmastlock[m_lock] && !mp[m_lock].v;
    if (!rst_v) begin
      chk("s_htrans", bus.s_htrans, (e_win >= 0) ? NONSEQ : IDLE);
      chk("s_haddr", bus.s_haddr, (e_win >= 0) ? 64'(e_fields.addr) : 64'd0);
      chk("s_hwrite", bus.s_hwrite, (e_win >= 0) ? 64'(e_fields.write) : 64'd0);
      chk("s_hsize", bus.s_hsize, (e_win >= 0) ? 64'(e_fields.size) : 64'd0);
      chk("s_hprot", bus.s_hprot, (e_win >= 0) ? 64'(e_fields.prot) : 64'd0);
      chk("s_hmastlock", bus.s_hmastlock, (e_win >= 0) ? 64'(e_fields.lock) : 64'd0);
      chk("s_hburst", bus.s_hburst, 64'd0);
      chk("m_hready", bus.m_hready, er);
      chk("m_hresp", bus.m_hresp, ep);
      chk("m_hrdata", bus.m_hrdata, {N{bus.s_hrdata}});
      if (m_dp >= 0) chk("s_hwdata", bus.s_hwdata, bus.m_hwdata[m_dp*DW +: DW]);
      if (bus.s_htrans == NONSEQ) issued.push_back(bus.s_haddr);
    end
  endtask

  task automatic commit();
    @(posedge hclk);
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        if (mq[i][0].trans[1]) begin
          if (e_rdy[i]) begin
            wd[i] = mq[i][0].wdata;
            void'(mq[i].pop_front());
          end
        end else begin
          void'(mq[i].pop_front());
        end
      end
    end
    if (rst_v) begin
      model_reset();
    end else begin
      if (e_win >= 0 && e_fields.lock) m_lock = e_win;
      else if (e_clear)                m_lock = -1;
      for (int i = 0; i < N; i++) begin
        if (e_win == i) mp[i].v = 1'b0;
        else if (e_live[i]) mp[i] = live_fields(i);
      end
      if (e_win >= 0) begin
        m_last = e_win;
        m_dp   = e_win;
      end else if (e_sready) begin
        m_dp = -1;
      end
    end
    srd = $urandom;
  endtask

  task automatic begin_cycle();
    #1;
    drive();
    eval();
  endtask

  task automatic tick();
    begin_cycle();
    commit();
  endtask

  task automatic do_reset();
    rst_v = 1'b1; sr = 1'b1; sp = 1'b0;
    tick();
    rst_v = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] exp_lock [4];
    exp_lock = '{32'h500, 32'h504, 32'h508, 32'h600};
    for (int i = 0; i < N; i++) wd[i] = '0;
    rst_v = 1'b1; sr = 1'b1; sp = 1'b0; srd = '0;
    model_reset();
    @(posedge hclk);

    // Reset state and a single read
    do_reset();
    begin_cycle();
    chk("rst_htrans", bus.s_htrans, IDLE);
    chk("rst_hready", bus.m_hready, 2'b11);
    chk("rst_hresp", bus.m_hresp, 2'b00);
    commit();
    mq[0].push_back(mk(NONSEQ, 32'h100, 1'b0, 1'b0, '0));
    begin_cycle();
    chk("rd_haddr", bus.s_haddr, 32'h100);
    chk("rd_htrans", bus.s_htrans, NONSEQ);
    chk("rd_hready0", bus.m_hready[0], 1'b1);
    commit();
    srd = 32'hDEADBEEF;
    begin_cycle();
    chk("rd_hready0_dp", bus.m_hready[0], 1'b1);
    chk("rd_hrdata", bus.m_hrdata[DW-1:0], 32'hDEADBEEF);
    commit();

    // Collision
    do_reset();
    mq[0].push_back(mk(NONSEQ, 32'h10, 1'b0, 1'b0, '0));
    mq[1].push_back(mk(NONSEQ, 32'h20, 1'b0, 1'b0, '0));
    begin_cycle();
    chk("col_c0_addr", bus.s_haddr, 32'h10);
    chk("col_c0_rdy1", bus.m_hready[1], 1'b1);
    commit();
    begin_cycle();
    chk("col_c1_addr", bus.s_haddr, 32'h20);
    chk("col_c1_rdy1", bus.m_hready[1], 1'b0);
    commit();
    begin_cycle();
    chk("col_c2_rdy1", bus.m_hready[1], 1'b1);
    commit();

    // Fairness
    do_reset();
    issued.delete();
    for (int k = 0; k < 4; k++) begin
      mq[0].push_back(mk(NONSEQ, 32'h1000 + 32'(4*k), 1'b0, 1'b0, '0));
      mq[1].push_back(mk(NONSEQ, 32'h2000 + 32'(4*k), 1'b0, 1'b0, '0));
    end
    repeat (10) tick();
    chk("fair_count", issued.size(), 8);
    for (int k = 0; k < 8 && k < issued.size(); k++) begin
      a = issued[k];
      chk("fair_order", a[13:12], (k % 2) + 1);
    end

    // Wait states with a buffered competitor
    do_reset();
    mq[0].push_back(mk(NONSEQ, 32'h300, 1'b1, 1'b0, 32'hA5A5A5A5));
    tick();
    mq[1].push_back(mk(NONSEQ, 32'h400, 1'b0, 1'b0, '0));
    sr = 1'b0;
    repeat (2) begin
      begin_cycle();
      chk("ws_hwdata", bus.s_hwdata, 32'hA5A5A5A5);
      chk("ws_idle", bus.s_htrans, IDLE);
      commit();
    end
    sr = 1'b1;
    begin_cycle();
    chk("ws_m1_addr", bus.s_haddr, 32'h400);
    chk("ws_m1_trans", bus.s_htrans, NONSEQ);
    commit();
    tick();

    // Locked sequence
    do_reset();
    issued.delete();
    mq[1].push_back(mk(NONSEQ, 32'h500, 1'b0, 1'b1, '0));
    mq[1].push_back(mk(NONSEQ, 32'h504, 1'b0, 1'b1, '0));
    mq[1].push_back(mk(NONSEQ, 32'h508, 1'b0, 1'b1, '0));
    mq[0].push_back(mk(IDLE, '0, 1'b0, 1'b0, '0));
    mq[0].push_back(mk(NONSEQ, 32'h600, 1'b0, 1'b0, '0));
    repeat (7) tick();
    chk("lock_count", issued.size(), 4);
    for (int k = 0; k < 4 && k < issued.size(); k++) chk("lock_order", issued[k], exp_lock[k]);

    // ERROR response
    do_reset();
    mq[0].push_back(mk(NONSEQ, 32'h700, 1'b0, 1'b0, '0));
    tick();
    mq[1].push_back(mk(NONSEQ, 32'h800, 1'b0, 1'b0, '0));
    sr = 1'b0; sp = 1'b1;
    begin_cycle();
    chk("err_c1_resp", bus.m_hresp, 2'b01);
    chk("err_c1_rdy0", bus.m_hready[0], 1'b0);
    commit();
    sr = 1'b1;
    begin_cycle();
    chk("err_c2_resp", bus.m_hresp, 2'b01);
    commit();
    sp = 1'b0;
    repeat (2) tick();

    // Reset with a buffered request
    do_reset();
    mq[0].push_back(mk(NONSEQ, 32'h900, 1'b0, 1'b0, '0));
    mq[1].push_back(mk(NONSEQ, 32'hA00, 1'b0, 1'b0, '0));
    tick();
    sr = 1'b0; rst_v = 1'b1;
    tick();
    rst_v = 1'b0; sr = 1'b1;
    begin_cycle();
    chk("mid_rst_htrans", bus.s_htrans, IDLE);
    chk("mid_rst_hready", bus.m_hready, 2'b11);
    chk("mid_rst_hresp", bus.m_hresp, 2'b00);
    commit();

    // Randomized traffic against the reference
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (mq[i].size() < 2 && $urandom_range(0, 2) == 0) mq[i].push_back(rnd_req());
      sr    = ($urandom_range(0, 3) != 0);
      sp    = ($urandom_range(0, 9) == 0);
      rst_v = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_v = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
